// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS execute-stage slice.
package mips_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ALU operation codes driven by the decoder
  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  // Multiply/divide and HI/LO access operation codes
  typedef enum logic [2:0] {
    MD_NONE   = 3'b000,
    MD_MULT   = 3'b001,
    MD_MULTU  = 3'b010,
    MD_DIV    = 3'b011,
    MD_DIVU   = 3'b100,
    MD_MFHI   = 3'b101,
    MD_MFLO   = 3'b110,
    MD_MTHILO = 3'b111
  } md_op_t;

  // Iterative multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_t;

  // True for the ops that launch an iterative multiply or divide
  function automatic logic md_is_start(input md_op_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Operands are reduced to magnitudes at start; signs are reapplied in DONE.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            mt_we,
  input  logic            mt_lo,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  md_state_t       state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] acc_r, low_r, opb_r, dvd_r, hi_r, lo_r;
  logic            is_div_r, neg_res_r, neg_rem_r, dz_r;

  logic            op_signed_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN:0]   add_s, shift_s;
  logic [XLEN-1:0] step_acc_s, step_low_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s, hi_fin_s, lo_fin_s;

  // Operand magnitudes and sign flags for the op being launched
  always_comb begin
    op_signed_s = (op == MD_MULT) || (op == MD_DIV);
    a_neg_s     = op_signed_s & a[XLEN-1];
    b_neg_s     = op_signed_s & b[XLEN-1];
    a_mag_s     = a_neg_s ? ({XLEN{1'b0}} - a) : a;
    b_mag_s     = b_neg_s ? ({XLEN{1'b0}} - b) : b;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    add_s   = {1'b0, acc_r} + (low_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    shift_s = {acc_r, low_r[XLEN-1]};
    if (is_div_r) begin
      if (shift_s >= {1'b0, opb_r}) begin
        step_acc_s = shift_s[XLEN-1:0] - opb_r;
        step_low_s = {low_r[XLEN-2:0], 1'b1};
      end else begin
        step_acc_s = shift_s[XLEN-1:0];
        step_low_s = {low_r[XLEN-2:0], 1'b0};
      end
    end else begin
      step_acc_s = add_s[XLEN:1];
      step_low_s = {add_s[0], low_r[XLEN-1:1]};
    end
  end

  // Sign correction and divide-by-zero override of the finished result
  always_comb begin
    prod_s = neg_res_r ? ({(2*XLEN){1'b0}} - {acc_r, low_r}) : {acc_r, low_r};
    quo_s  = neg_res_r ? ({XLEN{1'b0}} - low_r) : low_r;
    rem_s  = neg_rem_r ? ({XLEN{1'b0}} - acc_r) : acc_r;
    if (is_div_r && dz_r) begin
      hi_fin_s = dvd_r;
      lo_fin_s = {XLEN{1'b1}};
    end else if (is_div_r) begin
      hi_fin_s = rem_s;
      lo_fin_s = quo_s;
    end else begin
      hi_fin_s = prod_s[2*XLEN-1:XLEN];
      lo_fin_s = prod_s[XLEN-1:0];
    end
  end

  // Sequencer next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (start) state_nxt_s = MD_RUN;
        else       state_nxt_s = MD_IDLE;
      end
      MD_RUN: begin
        if (cnt_r == CNT_ONE) state_nxt_s = MD_DONE;
        else                  state_nxt_s = MD_RUN;
      end
      MD_DONE: state_nxt_s = MD_IDLE;
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!reset) state_r <= MD_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Working registers, iteration counter and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= {XLEN{1'b0}};
      low_r     <= {XLEN{1'b0}};
      opb_r     <= {XLEN{1'b0}};
      dvd_r     <= {XLEN{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      hi_r      <= {XLEN{1'b0}};
      lo_r      <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            cnt_r     <= CNT_LOAD;
            acc_r     <= {XLEN{1'b0}};
            low_r     <= a_mag_s;
            opb_r     <= b_mag_s;
            dvd_r     <= a;
            is_div_r  <= (op == MD_DIV) || (op == MD_DIVU);
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            dz_r      <= (b == {XLEN{1'b0}});
          end else if (mt_we) begin
            if (mt_lo) lo_r <= a;
            else       hi_r <= a;
          end
        end
        MD_RUN: begin
          acc_r <= step_acc_s;
          low_r <= step_low_s;
          cnt_r <= cnt_r - CNT_ONE;
        end
        MD_DONE: begin
          hi_r <= hi_fin_s;
          lo_r <= lo_fin_s;
        end
        default: cnt_r <= CNT_ZERO;
      endcase
    end
  end

  assign busy = (state_r != MD_IDLE);
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: ALU, destination mux, HI/LO forwarding and mult/div stall.
module execute_stage
  import mips_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] reg1_E,
  input  logic [XLEN-1:0] reg2_E,
  input  logic [4:0]      rt_E,
  input  logic [4:0]      rd_E,
  input  logic [XLEN-1:0] signimm_E,
  input  logic            alusrc_E,
  input  logic            regdst_E,
  input  logic [2:0]      alucontrol_E,
  input  logic [2:0]      mdop_E,
  output logic [XLEN-1:0] aluout_E,
  output logic [XLEN-1:0] writedata_E,
  output logic [4:0]      writereg_E,
  output logic            zero_E,
  output logic            stall_E,
  output logic            md_busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_op_t          mdop_s;
  logic [XLEN-1:0] srcb_s, alu_s, hi_s, lo_s;
  logic            busy_s, md_start_s, mt_we_s;

  assign mdop_s = md_op_t'(mdop_E);
  assign srcb_s = alusrc_E ? signimm_E : reg2_E;

  // Any HI/LO-touching op must wait while the sequencer is working
  assign stall_E    = busy_s && (mdop_s != MD_NONE);
  assign md_start_s = md_is_start(mdop_s) && !stall_E;
  assign mt_we_s    = (mdop_s == MD_MTHILO) && !stall_E;

  // Single-cycle ALU; unassigned codes yield zero
  always_comb begin
    alu_s = {XLEN{1'b0}};
    case (alu_op_t'(alucontrol_E))
      ALU_AND: alu_s = reg1_E & srcb_s;
      ALU_OR:  alu_s = reg1_E | srcb_s;
      ALU_ADD: alu_s = reg1_E + srcb_s;
      ALU_SUB: alu_s = reg1_E - srcb_s;
      ALU_SLT: alu_s = {{(XLEN-1){1'b0}}, ($signed(reg1_E) < $signed(srcb_s))};
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // HI/LO moves replace the ALU result when the unit is free
  always_comb begin
    aluout_E = alu_s;
    case (mdop_s)
      MD_MFHI: begin
        if (!busy_s) aluout_E = hi_s;
        else         aluout_E = alu_s;
      end
      MD_MFLO: begin
        if (!busy_s) aluout_E = lo_s;
        else         aluout_E = alu_s;
      end
      default: aluout_E = alu_s;
    endcase
  end

  assign zero_E      = (aluout_E == {XLEN{1'b0}});
  assign writedata_E = reg2_E;
  assign writereg_E  = regdst_E ? rd_E : rt_E;
  assign md_busy     = busy_s;
  assign hi          = hi_s;
  assign lo          = lo_s;

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start_s),
    .op    (mdop_s),
    .a     (reg1_E),
    .b     (reg2_E),
    .mt_we (mt_we_s),
    .mt_lo (rt_E[0]),
    .busy  (busy_s),
    .hi    (hi_s),
    .lo    (lo_s)
  );

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] reg1_E, reg2_E, signimm_E;
  logic [4:0]  rt_E, rd_E;
  logic        alusrc_E, regdst_E;
  logic [2:0]  alucontrol_E, mdop_E;
  logic [31:0] aluout_E, writedata_E, hi, lo;
  logic [4:0]  writereg_E;
  logic        zero_E, stall_E, md_busy;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .reg1_E(reg1_E), .reg2_E(reg2_E), .rt_E(rt_E),
    .rd_E(rd_E), .signimm_E(signimm_E), .alusrc_E(alusrc_E), .regdst_E(regdst_E),
    .alucontrol_E(alucontrol_E), .mdop_E(mdop_E), .aluout_E(aluout_E),
    .writedata_E(writedata_E), .writereg_E(writereg_E), .zero_E(zero_E),
    .stall_E(stall_E), .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (ctl)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Reference: 64-bit host arithmetic (division truncates toward zero, remainder follows dividend)
  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p, qb, rb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = 32'd0;
    l = 32'd0;
    if (op == 3'd1) begin
      p = sa * sb; h = p[63:32]; l = p[31:0];
    end else if (op == 3'd2) begin
      p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0];
    end else if (b == 32'd0) begin
      h = a; l = 32'hFFFFFFFF;
    end else if (op == 3'd3) begin
      q = sa / sb; r = sa % sb; qb = q; rb = r; l = qb[31:0]; h = rb[31:0];
    end else begin
      l = a / b; h = a % b;
    end
  endtask

  // Launch one mult/div and check latency plus HI/LO against the model
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int cnt;
    md_ref(op, a, b, eh, el);
    reg1_E = a; reg2_E = b; mdop_E = op;
    #1;
    check_val({tag, "_stall_at_issue"}, stall_E, 1'b0);
    tick();
    mdop_E = 3'd0;
    cnt = 0;
    while (md_busy && cnt < 200) begin
      cnt++;
      tick();
    end
    check_val({tag, "_busy_cycles"}, cnt, 33);
    check_val({tag, "_hi"}, hi, eh);
    check_val({tag, "_lo"}, lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ea;
    logic [2:0]  ctl;
    int cnt;

    reset = 1'b0; reg1_E = 32'd0; reg2_E = 32'd0; signimm_E = 32'd0;
    rt_E = 5'd0; rd_E = 5'd0; alusrc_E = 1'b0; regdst_E = 1'b0;
    alucontrol_E = 3'd0; mdop_E = 3'd0;
    repeat (2) tick();
    check_val("rst_busy", md_busy, 1'b0);
    check_val("rst_hi", hi, 32'd0);
    check_val("rst_lo", lo, 32'd0);
    check_val("rst_stall", stall_E, 1'b0);
    reset = 1'b1;

    // Directed ALU vectors
    reg1_E = 32'd5; signimm_E = 32'hFFFFFFFD; alusrc_E = 1'b1; alucontrol_E = 3'd2; #1;
    check_val("add_imm", aluout_E, 32'd2);
    check_val("add_zero", zero_E, 1'b0);
    reg2_E = 32'd5; alusrc_E = 1'b0; alucontrol_E = 3'd6; #1;
    check_val("sub_eq", aluout_E, 32'd0);
    check_val("sub_zero", zero_E, 1'b1);

    // Directed mult/div vectors from hand-worked values
    run_md("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd7);
    check_val("mult_neg_hi_k", hi, 32'hFFFFFFFF);
    check_val("mult_neg_lo_k", lo, 32'hFFFFFFEB);
    run_md("divu", 3'd4, 32'd100, 32'd7);
    check_val("divu_lo_k", lo, 32'd14);
    check_val("divu_hi_k", hi, 32'd2);
    run_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2);
    check_val("div_neg_lo_k", lo, 32'hFFFFFFFD);
    check_val("div_neg_hi_k", hi, 32'hFFFFFFFF);
    run_md("div_zero", 3'd3, 32'd9, 32'd0);
    check_val("div_zero_lo_k", lo, 32'hFFFFFFFF);
    check_val("div_zero_hi_k", hi, 32'd9);

    // MFLO right behind a MULT stalls until the unit is idle, then reads the new LO
    reg1_E = 32'd1234; reg2_E = 32'd5678; mdop_E = 3'd1; tick();
    mdop_E = 3'd6; alucontrol_E = 3'd2; #1;
    cnt = 0;
    while (md_busy && cnt < 200) begin
      check_val("mflo_stall", stall_E, 1'b1);
      cnt++;
      tick();
    end
    check_val("mflo_stall_cycles", cnt, 33);
    check_val("mflo_release", stall_E, 1'b0);
    check_val("mflo_value", aluout_E, 32'd7006652);
    mdop_E = 3'd5; #1;
    check_val("mfhi_value", aluout_E, 32'd0);

    // Start op presented while busy waits, then launches from IDLE
    reg1_E = 32'd3; reg2_E = 32'd4; mdop_E = 3'd2; tick();
    reg1_E = 32'd100; reg2_E = 32'd7; mdop_E = 3'd4; #1;
    cnt = 0;
    while (md_busy && cnt < 200) begin cnt++; tick(); end
    check_val("held_first_lo", lo, 32'd12);
    check_val("held_first_hi", hi, 32'd0);
    check_val("held_idle_stall", stall_E, 1'b0);
    tick();
    mdop_E = 3'd0;
    check_val("held_second_busy", md_busy, 1'b1);
    cnt = 0;
    while (md_busy && cnt < 200) begin cnt++; tick(); end
    check_val("held_second_lo", lo, 32'd14);
    check_val("held_second_hi", hi, 32'd2);

    // MTHI / MTLO selected by rt_E[0]
    reg1_E = 32'hCAFE0001; rt_E = 5'd0; mdop_E = 3'd7; tick();
    check_val("mthi", hi, 32'hCAFE0001);
    reg1_E = 32'hBEEF0002; rt_E = 5'd1; tick();
    mdop_E = 3'd0;
    check_val("mtlo", lo, 32'hBEEF0002);
    check_val("mtlo_hi_kept", hi, 32'hCAFE0001);

    // Reset in the middle of a multiply discards it
    reg1_E = 32'hFFFFFFFD; reg2_E = 32'd7; mdop_E = 3'd1; tick();
    mdop_E = 3'd0;
    repeat (10) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    mdop_E = 3'd6; #1;
    check_val("midrst_busy", md_busy, 1'b0);
    check_val("midrst_hi", hi, 32'd0);
    check_val("midrst_lo", lo, 32'd0);
    check_val("midrst_stall", stall_E, 1'b0);
    mdop_E = 3'd0;
    run_md("post_rst_multu", 3'd2, 32'd3, 32'd4);
    check_val("post_rst_lo_k", lo, 32'd12);
    check_val("post_rst_hi_k", hi, 32'd0);

    // Randomized ALU and datapath muxes
    for (int i = 0; i < 40; i++) begin
      ctl = 3'($urandom_range(0, 7));
      reg1_E = pick(); reg2_E = pick(); signimm_E = pick();
      alusrc_E = 1'($urandom_range(0, 1)); regdst_E = 1'($urandom_range(0, 1));
      rt_E = 5'($urandom_range(0, 31)); rd_E = 5'($urandom_range(0, 31));
      alucontrol_E = ctl; #1;
      ea = alu_ref(ctl, reg1_E, alusrc_E ? signimm_E : reg2_E);
      check_val("rnd_alu", aluout_E, ea);
      check_val("rnd_zero", zero_E, ea == 32'd0);
      check_val("rnd_wreg", writereg_E, regdst_E ? rd_E : rt_E);
      check_val("rnd_wdata", writedata_E, reg2_E);
    end

    // Randomized mult/div
    for (int i = 0; i < 30; i++) begin
      run_md("rnd_md", 3'($urandom_range(1, 4)), pick(), pick());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
